// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for the fetch stage.
// Owns the program counter, arbitrates trap / eret / branch / jump redirects,
// sequences instruction fetches over a req/ack handshake and inserts a fixed
// number of bubble cycles (with a one-cycle flush pulse) after every redirect.
module pc_sequencer #(
    parameter int unsigned       ADDR_W       = 16,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter logic [ADDR_W-1:0] TRAP_VECTOR  = 'h0100,
    parameter int unsigned       FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              trap,
    input  logic              do_eret,
    input  logic              do_branch,
    input  logic [ADDR_W-1:0] branch_address,
    input  logic              do_jump,
    input  logic [ADDR_W-1:0] jump_address,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    output logic              fetch_valid,
    output logic [ADDR_W-1:0] fetch_pc,
    output logic              flush,
    output logic [ADDR_W-1:0] epc,
    output logic [ADDR_W-1:0] pc
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

    state_t            state, state_n;
    logic [3:0]        flush_cnt, flush_cnt_n;
    logic [ADDR_W-1:0] pc_n, epc_n, fetch_pc_n;
    logic              fetch_valid_n, flush_n;
    logic              redirect;
    logic [ADDR_W-1:0] target;

    assign imem_addr = pc;

    // Redirect arbitration: trap > eret > branch > jump; ignored while booting.
    always_comb begin
        redirect = (state != BOOT) && (trap || do_eret || do_branch || do_jump);
        if (trap)
            target = TRAP_VECTOR;
        else if (do_eret)
            target = epc;
        else if (do_branch)
            target = branch_address;
        else
            target = jump_address;
    end

    // Next-state and next-output logic for the fetch sequencer.
    always_comb begin
        state_n       = state;
        flush_cnt_n   = flush_cnt;
        pc_n          = pc;
        epc_n         = epc;
        fetch_pc_n    = fetch_pc;
        fetch_valid_n = 1'b0;
        flush_n       = 1'b0;
        imem_req      = (state == FETCH) && !stall;

        case (state)
            BOOT: begin
                state_n = FETCH;
            end
            FETCH, FLUSH: begin
                if (redirect) begin
                    // Redirect wins over stall and ack; an acked fetch this cycle is dropped.
                    if (trap)
                        epc_n = pc;
                    pc_n    = target;
                    flush_n = 1'b1;
                    if (FLUSH_CYCLES == 0) begin
                        state_n = FETCH;
                    end else begin
                        state_n     = FLUSH;
                        flush_cnt_n = FLUSH_INIT;
                    end
                end else if (state == FLUSH) begin
                    flush_cnt_n = flush_cnt - 4'd1;
                    if (flush_cnt <= 4'd1)
                        state_n = FETCH;
                end else if (imem_req && imem_ack) begin
                    fetch_valid_n = 1'b1;
                    fetch_pc_n    = pc;
                    pc_n          = pc + ADDR_W'(1);
                end
            end
            default: begin
                state_n = BOOT;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= BOOT;
            flush_cnt   <= '0;
            pc          <= RESET_VECTOR;
            epc         <= '0;
            fetch_pc    <= '0;
            fetch_valid <= 1'b0;
            flush       <= 1'b0;
        end else begin
            state       <= state_n;
            flush_cnt   <= flush_cnt_n;
            pc          <= pc_n;
            epc         <= epc_n;
            fetch_pc    <= fetch_pc_n;
            fetch_valid <= fetch_valid_n;
            flush       <= flush_n;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed table of vectors, hand-written reset sequence,
// and randomized stimulus compared against a bubble-counting reference model.
module tb_pc_sequencer;

    localparam int unsigned ADDR_W = 16;
    localparam logic [15:0] TRAP_V = 16'h0100;
    localparam int          FC     = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0, trap = 1'b0, do_eret = 1'b0, do_branch = 1'b0, do_jump = 1'b0;
    logic [15:0] branch_address = '0, jump_address = '0;
    logic        imem_ack = 1'b0;
    logic        imem_req, fetch_valid, flush;
    logic [15:0] imem_addr, fetch_pc, epc, pc;

    int errors = 0;
    int checks = 0;

    pc_sequencer #(
        .ADDR_W      (ADDR_W),
        .RESET_VECTOR(16'h0000),
        .TRAP_VECTOR (TRAP_V),
        .FLUSH_CYCLES(FC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .trap          (trap),
        .do_eret       (do_eret),
        .do_branch     (do_branch),
        .branch_address(branch_address),
        .do_jump       (do_jump),
        .jump_address  (jump_address),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .fetch_valid   (fetch_valid),
        .fetch_pc      (fetch_pc),
        .flush         (flush),
        .epc           (epc),
        .pc            (pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  c;      // {stall, trap, eret, branch, jump, ack}
        logic [15:0] ba;
        logic [15:0] ja;
        logic        e_req;
        logic [15:0] e_pc;
        logic        e_fv;
        logic [15:0] e_fpc;
        logic        e_flush;
        logic [15:0] e_epc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [5:0] c, input logic [15:0] ba, input logic [15:0] ja,
                                input logic rq, input logic [15:0] p, input logic fv,
                                input logic [15:0] fp, input logic fl, input logic [15:0] ep);
        vec_t v;
        v.c = c; v.ba = ba; v.ja = ja; v.e_req = rq; v.e_pc = p; v.e_fv = fv;
        v.e_fpc = fp; v.e_flush = fl; v.e_epc = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [5:0] c, input logic [15:0] ba, input logic [15:0] ja);
        {stall, trap, do_eret, do_branch, do_jump, imem_ack} = c;
        branch_address = ba;
        jump_address   = ja;
    endtask

    // Reference model: a boot flag and a count of remaining bubble cycles.
    bit          m_boot;
    int          m_bub;
    logic [15:0] m_pc, m_epc, m_fpc;
    bit          m_fv, m_flush;

    function automatic bit m_req();
        return !m_boot && (m_bub == 0) && !stall;
    endfunction

    task automatic m_reset();
        m_boot = 1; m_bub = 0; m_pc = 16'h0000; m_epc = '0; m_fpc = '0; m_fv = 0; m_flush = 0;
    endtask

    task automatic m_step();
        logic [15:0] tgt;
        if (m_boot) begin
            m_boot = 0; m_fv = 0; m_flush = 0;
        end else if (trap || do_eret || do_branch || do_jump) begin
            tgt = trap ? TRAP_V : do_eret ? m_epc : do_branch ? branch_address : jump_address;
            if (trap) m_epc = m_pc;
            m_pc = tgt; m_flush = 1; m_fv = 0; m_bub = FC;
        end else begin
            m_flush = 0;
            if (m_bub > 0) begin
                m_bub--; m_fv = 0;
            end else if (!stall && imem_ack) begin
                m_fv = 1; m_fpc = m_pc; m_pc = m_pc + 16'd1;
            end else begin
                m_fv = 0;
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, imem_req, 0);
        chk({tag, "_pc"}, pc, 0);
        chk({tag, "_addr"}, imem_addr, 0);
        chk({tag, "_fv"}, fetch_valid, 0);
        chk({tag, "_fpc"}, fetch_pc, 0);
        chk({tag, "_flush"}, flush, 0);
        chk({tag, "_epc"}, epc, 0);
    endtask

    initial begin
        // Directed vectors starting at reset release (FLUSH_CYCLES=2).
        tbl.push_back(mk(6'b000001, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
        tbl.push_back(mk(6'b000001, 0, 0, 1, 16'h0001, 1, 16'h0000, 0, 16'h0000));
        tbl.push_back(mk(6'b000001, 0, 0, 1, 16'h0002, 1, 16'h0001, 0, 16'h0000));
        tbl.push_back(mk(6'b000001, 0, 0, 1, 16'h0003, 1, 16'h0002, 0, 16'h0000));
        tbl.push_back(mk(6'b000001, 0, 0, 1, 16'h0004, 1, 16'h0003, 0, 16'h0000));
        tbl.push_back(mk(6'b000001, 0, 0, 1, 16'h0005, 1, 16'h0004, 0, 16'h0000));
        tbl.push_back(mk(6'b000101, 16'h0040, 0, 1, 16'h0040, 0, 16'h0004, 1, 16'h0000));
        tbl.push_back(mk(6'b000001, 0, 0, 0, 16'h0040, 0, 16'h0004, 0, 16'h0000));
        tbl.push_back(mk(6'b000001, 0, 0, 0, 16'h0040, 0, 16'h0004, 0, 16'h0000));
        tbl.push_back(mk(6'b000001, 0, 0, 1, 16'h0041, 1, 16'h0040, 0, 16'h0000));
        tbl.push_back(mk(6'b000011, 0, 16'h0012, 1, 16'h0012, 0, 16'h0040, 1, 16'h0000));
        tbl.push_back(mk(6'b000001, 0, 0, 0, 16'h0012, 0, 16'h0040, 0, 16'h0000));
        tbl.push_back(mk(6'b000001, 0, 0, 0, 16'h0012, 0, 16'h0040, 0, 16'h0000));
        tbl.push_back(mk(6'b010111, 16'h0077, 16'h0099, 1, 16'h0100, 0, 16'h0040, 1, 16'h0012));
        tbl.push_back(mk(6'b000001, 0, 0, 0, 16'h0100, 0, 16'h0040, 0, 16'h0012));
        tbl.push_back(mk(6'b000001, 0, 0, 0, 16'h0100, 0, 16'h0040, 0, 16'h0012));
        tbl.push_back(mk(6'b000001, 0, 0, 1, 16'h0101, 1, 16'h0100, 0, 16'h0012));
        tbl.push_back(mk(6'b001101, 16'h0055, 0, 1, 16'h0012, 0, 16'h0100, 1, 16'h0012));
        tbl.push_back(mk(6'b100001, 0, 0, 0, 16'h0012, 0, 16'h0100, 0, 16'h0012));
        tbl.push_back(mk(6'b000001, 0, 0, 0, 16'h0012, 0, 16'h0100, 0, 16'h0012));
        tbl.push_back(mk(6'b000001, 0, 0, 1, 16'h0013, 1, 16'h0012, 0, 16'h0012));
        tbl.push_back(mk(6'b000011, 0, 16'h0007, 1, 16'h0007, 0, 16'h0012, 1, 16'h0012));
        tbl.push_back(mk(6'b000001, 0, 0, 0, 16'h0007, 0, 16'h0012, 0, 16'h0012));
        tbl.push_back(mk(6'b000001, 0, 0, 0, 16'h0007, 0, 16'h0012, 0, 16'h0012));
        tbl.push_back(mk(6'b100001, 0, 0, 0, 16'h0007, 0, 16'h0012, 0, 16'h0012));
        tbl.push_back(mk(6'b100001, 0, 0, 0, 16'h0007, 0, 16'h0012, 0, 16'h0012));
        tbl.push_back(mk(6'b100001, 0, 0, 0, 16'h0007, 0, 16'h0012, 0, 16'h0012));
        tbl.push_back(mk(6'b000001, 0, 0, 1, 16'h0008, 1, 16'h0007, 0, 16'h0012));
        tbl.push_back(mk(6'b000011, 0, 16'hFFFF, 1, 16'hFFFF, 0, 16'h0007, 1, 16'h0012));
        tbl.push_back(mk(6'b000001, 0, 0, 0, 16'hFFFF, 0, 16'h0007, 0, 16'h0012));
        tbl.push_back(mk(6'b000001, 0, 0, 0, 16'hFFFF, 0, 16'h0007, 0, 16'h0012));
        tbl.push_back(mk(6'b000001, 0, 0, 1, 16'h0000, 1, 16'hFFFF, 0, 16'h0012));
        tbl.push_back(mk(6'b000011, 0, 16'h0030, 1, 16'h0030, 0, 16'hFFFF, 1, 16'h0012));
        tbl.push_back(mk(6'b010001, 0, 0, 0, 16'h0100, 0, 16'hFFFF, 1, 16'h0030));
        tbl.push_back(mk(6'b000001, 0, 0, 0, 16'h0100, 0, 16'hFFFF, 0, 16'h0030));
        tbl.push_back(mk(6'b000001, 0, 0, 0, 16'h0100, 0, 16'hFFFF, 0, 16'h0030));
        tbl.push_back(mk(6'b000001, 0, 0, 1, 16'h0101, 1, 16'h0100, 0, 16'h0030));
        tbl.push_back(mk(6'b000000, 0, 0, 1, 16'h0101, 0, 16'h0100, 0, 16'h0030));
        tbl.push_back(mk(6'b100100, 16'h0055, 0, 0, 16'h0055, 0, 16'h0100, 1, 16'h0030));

        // Reset state.
        drive(6'b000001, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");

        // Directed table, entered at a falling edge with reset released.
        @(negedge clk);
        rst = 1'b1;
        foreach (tbl[i]) begin
            drive(tbl[i].c, tbl[i].ba, tbl[i].ja);
            #1;
            chk($sformatf("tbl%0d_req", i), imem_req, tbl[i].e_req);
            chk($sformatf("tbl%0d_addr", i), imem_addr, pc);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_pc", i), pc, tbl[i].e_pc);
            chk($sformatf("tbl%0d_fv", i), fetch_valid, tbl[i].e_fv);
            chk($sformatf("tbl%0d_fpc", i), fetch_pc, tbl[i].e_fpc);
            chk($sformatf("tbl%0d_flush", i), flush, tbl[i].e_flush);
            chk($sformatf("tbl%0d_epc", i), epc, tbl[i].e_epc);
            @(negedge clk);
        end

        // Jump to 0x80, then asynchronous reset in the middle of the bubble.
        drive(6'b000011, 0, 16'h0080);
        @(posedge clk);
        #1;
        chk("rstflush_pc", pc, 16'h0080);
        chk("rstflush_flush", flush, 1);
        @(negedge clk);
        drive(6'b000001, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_rst_boot_req", imem_req, 0);
        @(posedge clk);
        #1;
        chk("post_rst_req", imem_req, 1);
        chk("post_rst_addr", imem_addr, 16'h0000);
        @(posedge clk);
        #1;
        chk("post_rst_fv", fetch_valid, 1);
        chk("post_rst_fpc", fetch_pc, 16'h0000);
        chk("post_rst_pc", pc, 16'h0001);

        // Randomized run against the reference model.
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        m_reset();
        for (int n = 0; n < 1500; n++) begin
            stall     = ($urandom_range(0, 3) == 0);
            imem_ack  = ($urandom_range(0, 3) != 0);
            trap      = ($urandom_range(0, 19) == 0);
            do_eret   = ($urandom_range(0, 15) == 0);
            do_branch = ($urandom_range(0, 9) == 0);
            do_jump   = ($urandom_range(0, 9) == 0);
            branch_address = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFF - $urandom_range(0, 3))
                                                         : 16'($urandom);
            jump_address   = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFF - $urandom_range(0, 3))
                                                         : 16'($urandom);
            #1;
            chk("rnd_req", imem_req, m_req());
            chk("rnd_addr", imem_addr, m_pc);
            m_step();
            @(posedge clk);
            #1;
            chk("rnd_pc", pc, m_pc);
            chk("rnd_fv", fetch_valid, m_fv);
            chk("rnd_fpc", fetch_pc, m_fpc);
            chk("rnd_flush", flush, m_flush);
            chk("rnd_epc", epc, m_epc);
            chk("rnd_fv_flush_excl", fetch_valid & flush, 0);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
